label_accuracy_counter: RTL and testbench

- Downstream of the label-finder stage in the MLP inference path.
- Consumes one predicted label per inferred sample, together with the ground-truth label from the test-set memory.
- Counts correct predictions over a run of NUM_SAMPLES samples, then flags completion.
- Host/testbench reads correct_count to compute classification accuracy.

---
 rtl/label_accuracy_counter.sv | 156 +++++++++++++++
 tb/tb_label_accuracy_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/label_accuracy_counter.sv
// Counts correct label predictions over a run of NUM_SAMPLES samples, then raises done.
// Optional LABEL_ACC_FIRST_MISS_EN adds capture of the index of the first mispredicted sample.
module label_accuracy_counter #(
    parameter int unsigned number_of_labels       = 10,
    parameter int unsigned clog2_number_of_labels = 4,
    parameter int unsigned NUM_SAMPLES            = 100,
    parameter int unsigned CNT_W                  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              pred_valid,
    output logic                              pred_ready,
    input  logic [clog2_number_of_labels-1:0] pred_label,
    input  logic [clog2_number_of_labels-1:0] true_label,
    output logic                              busy,
    output logic                              done,
    output logic [CNT_W-1:0]                  correct_count,
    output logic [CNT_W-1:0]                  sample_count,
    output logic                              error_flag
`ifdef LABEL_ACC_FIRST_MISS_EN
    ,
    output logic                              first_miss_valid,
    output logic [CNT_W-1:0]                  first_miss_idx
`endif
);

    localparam logic [CNT_W-1:0] NumSamplesW = CNT_W'(NUM_SAMPLES);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] correct_count_q, correct_count_d;
    logic             error_flag_q, error_flag_d;

    logic             accept;
    logic             clear;
    logic             labels_ok;
    logic             hit;
    logic [31:0]      pred_ext;
    logic [31:0]      true_ext;
    logic [CNT_W-1:0] sample_inc;

    // Zero-extend so a label width that exactly covers number_of_labels still compares correctly.
    assign pred_ext   = 32'(pred_label);
    assign true_ext   = 32'(true_label);
    assign labels_ok  = (pred_ext < number_of_labels) && (true_ext < number_of_labels);
    assign hit        = labels_ok && (pred_label == true_label);
    assign accept     = pred_valid && (state_q == StRun);
    assign clear      = start && ((state_q == StIdle) || (state_q == StDone));
    assign sample_inc = sample_count_q + CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (accept && (sample_inc == NumSamplesW)) state_d = StDone;
            StDone:  if (start) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        pred_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StRun:   begin
                pred_ready = 1'b1;
                busy       = 1'b1;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        sample_count_d  = sample_count_q;
        correct_count_d = correct_count_q;
        error_flag_d    = error_flag_q;
        if (clear) begin
            sample_count_d  = '0;
            correct_count_d = '0;
            error_flag_d    = 1'b0;
        end else if (accept) begin
            sample_count_d = sample_inc;
            if (hit) begin
                correct_count_d = correct_count_q + CNT_W'(1);
            end
            if (!labels_ok) begin
                error_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_count_q  <= '0;
            correct_count_q <= '0;
            error_flag_q    <= 1'b0;
        end else begin
            sample_count_q  <= sample_count_d;
            correct_count_q <= correct_count_d;
            error_flag_q    <= error_flag_d;
        end
    end

    assign sample_count  = sample_count_q;
    assign correct_count = correct_count_q;
    assign error_flag    = error_flag_q;

`ifdef LABEL_ACC_FIRST_MISS_EN
    logic             first_miss_valid_q, first_miss_valid_d;
    logic [CNT_W-1:0] first_miss_idx_q, first_miss_idx_d;

    always_comb begin
        first_miss_valid_d = first_miss_valid_q;
        first_miss_idx_d   = first_miss_idx_q;
        if (clear) begin
            first_miss_valid_d = 1'b0;
            first_miss_idx_d   = '0;
        end else if (accept && !hit && !first_miss_valid_q) begin
            first_miss_valid_d = 1'b1;
            first_miss_idx_d   = sample_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_miss_valid_q <= 1'b0;
            first_miss_idx_q   <= '0;
        end else begin
            first_miss_valid_q <= first_miss_valid_d;
            first_miss_idx_q   <= first_miss_idx_d;
        end
    end

    assign first_miss_valid = first_miss_valid_q;
    assign first_miss_idx   = first_miss_idx_q;
`endif

endmodule

// File: tb/tb_label_accuracy_counter.sv
// Directed bench for label_accuracy_counter: one instance with NUM_SAMPLES=4, one with 1.
// Define LABEL_ACC_FIRST_MISS_EN to also check the first-miss capture ports.
module tb_label_accuracy_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pred_valid = 1'b0;
    logic [3:0]  pred_label = 4'd0;
    logic [3:0]  true_label = 4'd0;

    logic        ready_a, busy_a, done_a, err_a;
    logic [15:0] correct_a, sample_a;
    logic        ready_b, busy_b, done_b, err_b;
    logic [15:0] correct_b, sample_b;
`ifdef LABEL_ACC_FIRST_MISS_EN
    logic        fmv_a, fmv_b;
    logic [15:0] fmi_a, fmi_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    label_accuracy_counter #(
        .number_of_labels(10), .clog2_number_of_labels(4), .NUM_SAMPLES(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pred_valid(pred_valid), .pred_ready(ready_a),
        .pred_label(pred_label), .true_label(true_label), .busy(busy_a), .done(done_a),
        .correct_count(correct_a), .sample_count(sample_a), .error_flag(err_a)
`ifdef LABEL_ACC_FIRST_MISS_EN
        , .first_miss_valid(fmv_a), .first_miss_idx(fmi_a)
`endif
    );

    label_accuracy_counter #(
        .number_of_labels(10), .clog2_number_of_labels(4), .NUM_SAMPLES(1), .CNT_W(16)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start), .pred_valid(pred_valid), .pred_ready(ready_b),
        .pred_label(pred_label), .true_label(true_label), .busy(busy_b), .done(done_b),
        .correct_count(correct_b), .sample_count(sample_b), .error_flag(err_b)
`ifdef LABEL_ACC_FIRST_MISS_EN
        , .first_miss_valid(fmv_b), .first_miss_idx(fmi_b)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_a); end
        n_vec++; if (sample_a !== 16'd0) begin n_err++; $display("FAIL reset_sample: got %0d want 0", sample_a); end
        n_vec++; if (correct_a !== 16'd0) begin n_err++; $display("FAIL reset_correct: got %0d want 0", correct_a); end
        n_vec++; if (err_a !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b want 0", err_a); end
`ifdef LABEL_ACC_FIRST_MISS_EN
        n_vec++; if ({fmv_a, fmi_a} !== 17'd0) begin n_err++; $display("FAIL reset_first_miss: got %b/%0d want 0/0", fmv_a, fmi_a); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [3:0] p [4] = '{4'd3, 4'd7, 4'd2, 4'd9};
        logic [3:0] t [4] = '{4'd3, 4'd7, 4'd5, 4'd9};
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++; if ({busy_a, ready_a, done_a} !== 3'b110) begin n_err++; $display("FAIL b2b_enter_run: got busy/ready/done=%b%b%b want 110", busy_a, ready_a, done_a); end
        for (int i = 0; i < 4; i++) begin
            pred_valid = 1'b1;
            pred_label = p[i];
            true_label = t[i];
            step();
            if (i == 1) begin
                n_vec++; if (sample_a !== 16'd2) begin n_err++; $display("FAIL b2b_mid_sample: got %0d want 2", sample_a); end
                n_vec++; if (correct_a !== 16'd2) begin n_err++; $display("FAIL b2b_mid_correct: got %0d want 2", correct_a); end
            end
        end
        pred_valid = 1'b0;
        n_vec++; if ({done_a, ready_a, busy_a} !== 3'b100) begin n_err++; $display("FAIL b2b_done: got done/ready/busy=%b%b%b want 100", done_a, ready_a, busy_a); end
        n_vec++; if (correct_a !== 16'd3) begin n_err++; $display("FAIL b2b_correct: got %0d want 3", correct_a); end
        n_vec++; if (sample_a !== 16'd4) begin n_err++; $display("FAIL b2b_sample: got %0d want 4", sample_a); end
        n_vec++; if (err_a !== 1'b0) begin n_err++; $display("FAIL b2b_error: got %b want 0", err_a); end
`ifdef LABEL_ACC_FIRST_MISS_EN
        n_vec++; if ({fmv_a, fmi_a} !== {1'b1, 16'd2}) begin n_err++; $display("FAIL b2b_first_miss: got %b/%0d want 1/2", fmv_a, fmi_a); end
`endif
    endtask

    task automatic test_valid_toggle();
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++; if ({busy_a, sample_a, correct_a} !== {1'b1, 32'd0}) begin n_err++; $display("FAIL toggle_restart: got busy=%b sample=%0d correct=%0d want 1/0/0", busy_a, sample_a, correct_a); end
        for (int i = 0; i < 7; i++) begin
            pred_valid = (i % 2 == 0);
            pred_label = 4'd1;
            true_label = 4'd1;
            step();
            n_vec++; if (sample_a !== 16'(i / 2 + 1)) begin n_err++; $display("FAIL toggle_sample_%0d: got %0d want %0d", i, sample_a, i / 2 + 1); end
        end
        pred_valid = 1'b0;
        n_vec++; if ({done_a, correct_a} !== {1'b1, 16'd4}) begin n_err++; $display("FAIL toggle_done: got done=%b correct=%0d want 1/4", done_a, correct_a); end
    endtask

    task automatic test_out_of_range();
        logic [3:0] p [4] = '{4'd12, 4'd4, 4'd0, 4'd5};
        logic [3:0] t [4] = '{4'd12, 4'd4, 4'd15, 4'd5};
        logic [15:0] exp_c [4] = '{16'd0, 16'd1, 16'd1, 16'd2};
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pred_valid = 1'b1;
            pred_label = p[i];
            true_label = t[i];
            step();
            n_vec++; if (err_a !== 1'b1) begin n_err++; $display("FAIL oor_error_%0d: got %b want 1", i, err_a); end
            n_vec++; if (correct_a !== exp_c[i]) begin n_err++; $display("FAIL oor_correct_%0d: got %0d want %0d", i, correct_a, exp_c[i]); end
            n_vec++; if (sample_a !== 16'(i + 1)) begin n_err++; $display("FAIL oor_sample_%0d: got %0d want %0d", i, sample_a, i + 1); end
        end
        pred_valid = 1'b0;
        n_vec++; if (done_a !== 1'b1) begin n_err++; $display("FAIL oor_done: got %b want 1", done_a); end
`ifdef LABEL_ACC_FIRST_MISS_EN
        n_vec++; if ({fmv_a, fmi_a} !== {1'b1, 16'd0}) begin n_err++; $display("FAIL oor_first_miss: got %b/%0d want 1/0", fmv_a, fmi_a); end
`endif
    endtask

    task automatic test_done_hold();
        pred_label = 4'd6;
        true_label = 4'd6;
        for (int i = 0; i < 3; i++) begin
            pred_valid = 1'b1;
            step();
            n_vec++; if ({done_a, ready_a} !== 2'b10) begin n_err++; $display("FAIL hold_state_%0d: got done/ready=%b%b want 10", i, done_a, ready_a); end
            n_vec++; if ({sample_a, correct_a, err_a} !== {16'd4, 16'd2, 1'b1}) begin n_err++; $display("FAIL hold_counts_%0d: got %0d/%0d/%b want 4/2/1", i, sample_a, correct_a, err_a); end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        pred_valid = 1'b0;
        n_vec++; if ({busy_a, done_a} !== 2'b10) begin n_err++; $display("FAIL hold_restart_state: got busy/done=%b%b want 10", busy_a, done_a); end
        n_vec++; if ({sample_a, correct_a, err_a} !== 33'd0) begin n_err++; $display("FAIL hold_restart_clear: got %0d/%0d/%b want 0/0/0", sample_a, correct_a, err_a); end
`ifdef LABEL_ACC_FIRST_MISS_EN
        n_vec++; if (fmv_a !== 1'b0) begin n_err++; $display("FAIL hold_restart_first_miss: got %b want 0", fmv_a); end
`endif
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 2; i++) begin
            pred_valid = 1'b1;
            pred_label = 4'(i + 1);
            true_label = 4'(i + 1);
            step();
        end
        n_vec++; if (sample_a !== 16'd2) begin n_err++; $display("FAIL midrst_before: got %0d want 2", sample_a); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++; if ({ready_a, busy_a, done_a, err_a} !== 4'b0000) begin n_err++; $display("FAIL midrst_flags: got %b%b%b%b want 0000", ready_a, busy_a, done_a, err_a); end
        n_vec++; if ({sample_a, correct_a} !== 32'd0) begin n_err++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", sample_a, correct_a); end
        step();
        step();
        pred_valid = 1'b0;
        n_vec++; if ({sample_a, busy_a} !== 17'd0) begin n_err++; $display("FAIL midrst_idle_ignore: got sample=%0d busy=%b want 0/0", sample_a, busy_a); end
    endtask

    task automatic test_start_with_valid();
        start = 1'b1;
        pred_valid = 1'b1;
        pred_label = 4'd3;
        true_label = 4'd3;
        step();
        start = 1'b0;
        n_vec++; if ({busy_b, ready_b, sample_b} !== {2'b11, 16'd0}) begin n_err++; $display("FAIL swv_not_taken: got busy=%b ready=%b sample=%0d want 1/1/0", busy_b, ready_b, sample_b); end
        step();
        pred_valid = 1'b0;
        n_vec++; if ({done_b, ready_b, busy_b} !== 3'b100) begin n_err++; $display("FAIL swv_done: got done/ready/busy=%b%b%b want 100", done_b, ready_b, busy_b); end
        n_vec++; if ({sample_b, correct_b} !== {16'd1, 16'd1}) begin n_err++; $display("FAIL swv_counts: got %0d/%0d want 1/1", sample_b, correct_b); end
        step();
        n_vec++; if (sample_b !== 16'd1) begin n_err++; $display("FAIL swv_hold: got %0d want 1", sample_b); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_valid_toggle();
        test_out_of_range();
        test_done_hold();
        test_reset_mid_run();
        test_start_with_valid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
